hwpe_ctrl_offloader: RTL
========================

// Module: hwpe_ctrl_offloader
// PURPOSE
//   Initiator-side offload engine for an HWPE control slave. Accepts one job descriptor
//   (N_IO_REGS words) from a local controller, then drives the peripheral bus: ACQUIRE read
//   (retried with backoff while busy), programs IO registers, writes TRIGGER, waits for the
//   HWPE event and reads FINISHED to clear it. Sits between a core-side sequencer and the HWPE slave port.
// PARAMETERS
//   N_IO_REGS      2         job words written per offload (1..32)
//   ID_WIDTH       16        peripheral transaction id width
//   BASE_ADDR      32'h0     HWPE slave base byte address
//   TRIGGER_OFS    32'h00    byte offset of TRIGGER; ACQUIRE_OFS 32'h04; FINISHED_OFS 32'h08
//   IO_OFS         32'h40    byte offset of IO register 0 (word-stride 4)
//   BACKOFF_CYC    8         idle cycles between ACQUIRE retries (>=1)
//   MAX_RETRY      255       ACQUIRE attempts before error (1..255)
// PORTS
//   clk_i        in   1               clock
//   rst_ni       in   1               reset, synchronous, active-low
//   job_valid_i  in   1               descriptor valid
//   job_ready_o  out  1               high only in IDLE
//   job_regs_i   in   N_IO_REGS*32    descriptor, word k -> IO_OFS+4k
//   done_o       out  1               1-cycle pulse at job end
//   err_o        out  1               valid with done_o: 1 = retries exhausted, job not run
//   job_id_o     out  8               id returned by ACQUIRE, valid with done_o
//   evt_i        in   1               HWPE completion event (level or pulse)
//   periph_req_o out  1               request
//   periph_gnt_i in   1               grant
//   periph_add_o out  32              byte address
//   periph_wen_o out  1               1 = read, 0 = write
//   periph_be_o  out  4               byte enables, always 4'hF
//   periph_data_o out 32              write data
//   periph_id_o  out  ID_WIDTH        constant 0
//   periph_r_valid_i in 1             response valid (reads and writes)
//   periph_r_data_i  in 32            read data
// BEHAVIOUR
//   - Reset (rst_ni=0 at clk edge): state IDLE; job_ready_o=1; done_o, err_o, periph_req_o=0;
//     job_id_o=0; add/data=0; wen=1; retry/backoff/word counters=0; evt latch=0. Reset mid-job abandons it.
//   - One outstanding transaction. req held with stable add/wen/data until gnt; req drops the
//     cycle after gnt; transaction completes on r_valid (earliest cycle after gnt).
//   - Descriptor captured into internal register on job_valid_i & job_ready_o; inputs may change after.
//   - FSM: IDLE -> ACQ (read BASE+ACQUIRE_OFS) -> ACQ_WAIT. On r_valid:
//       rdata==32'hFFFF_FFFE or 32'hFFFF_FFFF: retry_cnt++; if retry_cnt==MAX_RETRY -> DONE(err=1)
//       else BACKOFF (BACKOFF_CYC cycles, req=0) -> ACQ.
//       else job_id <= rdata[7:0] -> PROG (word_cnt=0), or TRIG if N_IO_REGS==0 not allowed.
//     PROG: write word[word_cnt] to BASE+IO_OFS+4*word_cnt -> PROG_WAIT; on r_valid word_cnt++;
//       after word N_IO_REGS-1 -> TRIG.
//     TRIG: write 32'h0 to BASE+TRIGGER_OFS -> TRIG_WAIT -> RUN on r_valid.
//     RUN: wait evt latch -> FIN: read BASE+FINISHED_OFS -> FIN_WAIT -> DONE on r_valid.
//     DONE: done_o=1 one cycle, err_o per path, job_id_o updated -> IDLE.
//   - evt_i latched from entry to TRIG (inclusive) until consumed in RUN; an evt_i arriving
//     before RUN is not lost. evt_i outside TRIG..RUN ignored.
//   - retry_cnt 8-bit, cleared at job capture; no wrap (saturates at MAX_RETRY).
//   - job_id_o holds last value between jobs; on error it keeps the previous job's id.
//   - r_valid without outstanding request ignored; gnt while req=0 ignored.
//   - Back-to-back: job_ready_o rises the cycle after done_o; new job may be captured then.
// TESTING
//   1 Reset then job {A,B}, slave ACQUIRE returns 5 -> bus: R 0x04, W 0x40=A, W 0x44=B,
//     W 0x00=0; evt_i pulse -> R 0x08; done_o=1, err_o=0, job_id_o=5.
//   2 ACQUIRE returns -1 twice then 7, BACKOFF_CYC=8 -> 3 ACQUIRE reads, >=8 req-free cycles
//     between them, job_id_o=7.
//   3 MAX_RETRY=3, ACQUIRE always -2 -> exactly 3 reads, then done_o=1, err_o=1, no writes issued.
//   4 gnt delayed 5 cycles on each request -> add/data/wen stable while req=1, single txn each.
//   5 evt_i pulsed during TRIG_WAIT (before RUN) -> FINISHED read still issued, done_o asserted.
//   6 rst_ni low during PROG_WAIT -> next cycle req=0, job_ready_o=1; fresh job runs cleanly.

Source files
------------

// File: rtl/hwpe_ctrl_offloader_if.sv
// Peripheral bus between the offload engine (master) and an HWPE control slave.
// One outstanding transaction: req/add/wen/data held until gnt, response on r_valid.
interface hwpe_ctrl_offloader_if #(
  parameter int unsigned ID_WIDTH = 16
) ();
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [31:0]         r_data;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data
  );
endinterface

// File: rtl/hwpe_ctrl_offloader.sv
// Offload engine: acquires an HWPE context (with backoff while busy), programs the IO
// registers from a captured descriptor, triggers, waits for the event and clears FINISHED.
module hwpe_ctrl_offloader #(
  parameter int unsigned N_IO_REGS    = 2,
  parameter int unsigned ID_WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter logic [31:0] TRIGGER_OFS  = 32'h00,
  parameter logic [31:0] ACQUIRE_OFS  = 32'h04,
  parameter logic [31:0] FINISHED_OFS = 32'h08,
  parameter logic [31:0] IO_OFS       = 32'h40,
  parameter int unsigned BACKOFF_CYC  = 8,
  parameter int unsigned MAX_RETRY    = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [N_IO_REGS*32-1:0] job_regs_i,
  output logic                   done_o,
  output logic                   err_o,
  output logic [7:0]             job_id_o,
  input  logic                   evt_i,
  hwpe_ctrl_offloader_if.master  periph
);

  localparam int unsigned WCNT_W = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam int unsigned BCNT_W = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD    = WCNT_W'(N_IO_REGS - 1);
  localparam logic [BCNT_W-1:0] LAST_BACKOFF = BCNT_W'(BACKOFF_CYC - 1);
  localparam logic [7:0]        LAST_RETRY   = 8'(MAX_RETRY - 1);
  localparam logic [7:0]        SAT_RETRY    = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_ACQ, S_ACQ_WAIT, S_BACKOFF, S_PROG, S_PROG_WAIT,
    S_TRIG, S_TRIG_WAIT, S_RUN, S_FIN, S_FIN_WAIT, S_DONE
  } state_e;

  state_e                 state_reg, state_next;
  logic [31:0]            add_reg, add_next;
  logic [31:0]            data_reg, data_next;
  logic                   wen_reg, wen_next;
  logic [7:0]             retry_reg, retry_next;
  logic [BCNT_W-1:0]      bcnt_reg, bcnt_next;
  logic [WCNT_W-1:0]      wcnt_reg, wcnt_next;
  logic [7:0]             id_pend_reg, id_pend_next;
  logic [7:0]             id_out_reg, id_out_next;
  logic                   err_reg, err_next;
  logic                   evt_reg, evt_next;
  logic [N_IO_REGS*32-1:0] job_reg;
  logic                   capture;
  logic                   evt_window;
  logic                   acq_busy;
  logic [WCNT_W-1:0]      wcnt_inc;
  logic [31:0]            job_word [N_IO_REGS];

  for (genvar gi = 0; gi < N_IO_REGS; gi++) begin : g_word
    assign job_word[gi] = job_reg[gi*32 +: 32];
  end

  assign evt_window = (state_reg == S_TRIG) || (state_reg == S_TRIG_WAIT) || (state_reg == S_RUN);
  // Both all-ones and all-ones-minus-one mean the slave has no free context
  assign acq_busy   = (periph.r_data[31:1] == 31'h7FFF_FFFF);
  assign wcnt_inc   = wcnt_reg + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= S_IDLE;
      add_reg     <= '0;
      data_reg    <= '0;
      wen_reg     <= 1'b1;
      retry_reg   <= '0;
      bcnt_reg    <= '0;
      wcnt_reg    <= '0;
      id_pend_reg <= '0;
      id_out_reg  <= '0;
      err_reg     <= 1'b0;
      evt_reg     <= 1'b0;
      job_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      add_reg     <= add_next;
      data_reg    <= data_next;
      wen_reg     <= wen_next;
      retry_reg   <= retry_next;
      bcnt_reg    <= bcnt_next;
      wcnt_reg    <= wcnt_next;
      id_pend_reg <= id_pend_next;
      id_out_reg  <= id_out_next;
      err_reg     <= err_next;
      evt_reg     <= evt_next;
      if (capture) begin
        job_reg <= job_regs_i;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    add_next     = add_reg;
    data_next    = data_reg;
    wen_next     = wen_reg;
    retry_next   = retry_reg;
    bcnt_next    = bcnt_reg;
    wcnt_next    = wcnt_reg;
    id_pend_next = id_pend_reg;
    id_out_next  = id_out_reg;
    err_next     = err_reg;
    evt_next     = evt_reg | (evt_i & evt_window);
    capture      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (job_valid_i) begin
          capture    = 1'b1;
          retry_next = '0;
          wcnt_next  = '0;
          bcnt_next  = '0;
          err_next   = 1'b0;
          evt_next   = 1'b0;
          add_next   = BASE_ADDR + ACQUIRE_OFS;
          wen_next   = 1'b1;
          data_next  = '0;
          state_next = S_ACQ;
        end
      end
      S_ACQ: if (periph.gnt) state_next = S_ACQ_WAIT;
      S_ACQ_WAIT: begin
        if (periph.r_valid) begin
          if (acq_busy) begin
            if (retry_reg == LAST_RETRY) begin
              retry_next = SAT_RETRY;
              err_next   = 1'b1;
              state_next = S_DONE;
            end else begin
              retry_next = retry_reg + 8'd1;
              bcnt_next  = '0;
              state_next = S_BACKOFF;
            end
          end else begin
            id_pend_next = periph.r_data[7:0];
            wcnt_next    = '0;
            add_next     = BASE_ADDR + IO_OFS;
            data_next    = job_word[0];
            wen_next     = 1'b0;
            state_next   = S_PROG;
          end
        end
      end
      // add/wen still hold the ACQUIRE read, so only the wait needs counting
      S_BACKOFF: begin
        if (bcnt_reg == LAST_BACKOFF) begin
          state_next = S_ACQ;
        end else begin
          bcnt_next = bcnt_reg + 1'b1;
        end
      end
      S_PROG: if (periph.gnt) state_next = S_PROG_WAIT;
      S_PROG_WAIT: begin
        if (periph.r_valid) begin
          if (wcnt_reg == LAST_WORD) begin
            add_next   = BASE_ADDR + TRIGGER_OFS;
            data_next  = '0;
            wen_next   = 1'b0;
            state_next = S_TRIG;
          end else begin
            wcnt_next  = wcnt_inc;
            add_next   = BASE_ADDR + IO_OFS + 32'({wcnt_inc, 2'b00});
            data_next  = job_word[wcnt_inc];
            state_next = S_PROG;
          end
        end
      end
      S_TRIG: if (periph.gnt) state_next = S_TRIG_WAIT;
      S_TRIG_WAIT: if (periph.r_valid) state_next = S_RUN;
      S_RUN: begin
        if (evt_reg || evt_i) begin
          evt_next   = 1'b0;
          add_next   = BASE_ADDR + FINISHED_OFS;
          data_next  = '0;
          wen_next   = 1'b1;
          state_next = S_FIN;
        end
      end
      S_FIN: if (periph.gnt) state_next = S_FIN_WAIT;
      S_FIN_WAIT: begin
        if (periph.r_valid) begin
          id_out_next = id_pend_reg;
          err_next    = 1'b0;
          state_next  = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign job_ready_o = (state_reg == S_IDLE);
  assign done_o      = (state_reg == S_DONE);
  assign err_o       = (state_reg == S_DONE) && err_reg;
  assign job_id_o    = id_out_reg;

  assign periph.req  = (state_reg == S_ACQ) || (state_reg == S_PROG) ||
                       (state_reg == S_TRIG) || (state_reg == S_FIN);
  assign periph.add  = add_reg;
  assign periph.wen  = wen_reg;
  assign periph.data = data_reg;
  assign periph.be   = 4'hF;
  assign periph.id   = ID_WIDTH'(0);

endmodule
